seg7_game_disp: RTL and testbench
=================================

SEG7_GAME_DISP -- requirements
Module: seg7_game_disp

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of 7-segment digits driven (legal 2..8).
REQ-002 SHALL have parameter BLINK_W, default 24, meaning blink prescaler counter width in bits (legal 2..32).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port STATE  input  4  game state code.
REQ-006 SHALL have port QUE  input  4  question digit, BCD 0..9.
REQ-007 SHALL have port DIN  input  4  answer code 0..9.
REQ-008 SHALL have port DIN_VLD  input  1  single-cycle strobe: DIN holds a newly entered answer code.
REQ-009 SHALL have port nHEX  output  7*NDIG  active-low segments; digit k occupies bits [7k+6:7k], order gfedcba; digit 0 is rightmost.

Function
REQ-010 Glyphs, active-low gfedcba: blank 1111111, dash 0111111, A 0001000, O 1000000, U 1000001, t 0000111, E 0000110; digits 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000.
REQ-011 Answer-code map: 0->dash, 1->2, 2->3, 3->5, 4->7, 5->1, 6->3, 7->7, 8->9, 9->3, 10..15->blank.
REQ-012 nHEX SHALL be registered; a change on STATE, QUE or the history appears on nHEX exactly one clock later.
REQ-013 History: NDIG entries of 4-bit codes, H[0] newest; on a DIN_VLD cycle while STATE=0100, H[k]<=H[k-1] for k>=1, H[0]<=DIN, oldest entry discarded.
REQ-014 DIN_VLD while STATE!=0100 SHALL be ignored.
REQ-015 On the first cycle STATE=0100 after any other state, all history entries SHALL load code 15 (blank); a DIN_VLD on that same cycle SHALL be written to H[0] after the clear.
REQ-016 STATE 0010 (READY): digit0=A; others blank.
REQ-017 STATE 0011 (QUESTION): digit0=QUE decoded; QUE>9 gives blank; others blank.
REQ-018 STATE 0100 (INPUT): digit k = answer-code map of H[k], for all k.
REQ-019 STATE 1000 GOOD=O, 0111 WRONG=A, 1001 OUCH=U, 0110 DRAW=t, 1010 WIN=E, 1011 LOSE=O, each on digit0; others blank.
REQ-020 Any other STATE code: all digits blank; no latching of the previous value.
REQ-021 Blink prescaler: free-running BLINK_W-bit up-counter, wraps from all-ones to 0; blink phase = counter MSB.
REQ-022 History and prescaler SHALL keep running and updating regardless of STATE, except as REQ-014/015 state.

Reset
REQ-023 RST high SHALL immediately force nHEX to all ones (all blank), all history entries to 15, prescaler to 0, previous-state register to 0000.
REQ-024 Reset asserted mid-entry SHALL discard the history; after release, the first cycle in STATE 0100 is treated as a fresh entry (REQ-015).

Configuration
REQ-025 Macro SEG7_GAME_BLINK_EN: when defined, in STATE 0111 (WRONG) and 1001 (OUCH) all digits SHALL be blank while blink phase=1 and show REQ-019 glyph while phase=0.
REQ-026 Without SEG7_GAME_BLINK_EN, no prescaler is built and WRONG/OUCH glyphs are shown steadily.

Verification
REQ-027 Reset, then STATE=0010 -> nHEX all ones during reset; one clock after release digit0=0001000, digits1..3=1111111.
REQ-028 STATE=0011, QUE=7, then QUE=12 -> digit0=1011000 one clock later, then 1111111 one clock after the change.
REQ-029 Enter 0100, strobe DIN 1,2,3,4,8 on five cycles -> digits3..0 = 3,5,7,9 (0110000, 0010010, 1011000, 0010000); the oldest code 1 is dropped.
REQ-030 Leave 0100 for 1000 and return -> GOOD shows O on digit0; on return all digits blank; DIN_VLD in state 0011 leaves history unchanged.
REQ-031 SEG7_GAME_BLINK_EN defined, BLINK_W=4, STATE=0111 -> digit0 alternates 0001000 / 1111111 every 8 clocks; undefined -> steady 0001000.
REQ-032 STATE=0101 and STATE=1111 -> nHEX all ones one clock later.

Source files
------------

// File: rtl/seg7_game_disp.sv
// seg7_game_disp: registered multi-digit 7-segment driver for a reaction game.
// Define SEG7_GAME_BLINK_EN to blink the WRONG/OUCH glyphs from a free-running prescaler.
module seg7_game_disp #(
    parameter int NDIG    = 4,
    parameter int BLINK_W = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        STATE,
    input  logic [3:0]        QUE,
    input  logic [3:0]        DIN,
    input  logic              DIN_VLD,
    output logic [7*NDIG-1:0] nHEX
);

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_A     = 7'b0001000;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_T     = 7'b0000111;
    localparam logic [6:0] G_E     = 7'b0000110;

    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_QUEST = 4'b0011;
    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_DRAW  = 4'b0110;
    localparam logic [3:0] ST_WRONG = 4'b0111;
    localparam logic [3:0] ST_GOOD  = 4'b1000;
    localparam logic [3:0] ST_OUCH  = 4'b1001;
    localparam logic [3:0] ST_WIN   = 4'b1010;
    localparam logic [3:0] ST_LOSE  = 4'b1011;

    if (NDIG < 2 || NDIG > 8) begin : g_bad_ndig
        $error("seg7_game_disp: NDIG out of range 2..8");
    end
    if (BLINK_W < 2 || BLINK_W > 32) begin : g_bad_blink_w
        $error("seg7_game_disp: BLINK_W out of range 2..32");
    end

    function automatic logic [6:0] dig_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1011000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    // Answer codes map onto the digit each key represents.
    function automatic logic [6:0] ans_glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'd0:    g = G_DASH;
            4'd1:    g = dig_glyph(4'd2);
            4'd2:    g = dig_glyph(4'd3);
            4'd3:    g = dig_glyph(4'd5);
            4'd4:    g = dig_glyph(4'd7);
            4'd5:    g = dig_glyph(4'd1);
            4'd6:    g = dig_glyph(4'd3);
            4'd7:    g = dig_glyph(4'd7);
            4'd8:    g = dig_glyph(4'd9);
            4'd9:    g = dig_glyph(4'd3);
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    logic [7*NDIG-1:0] nhex_q, nhex_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        hist_q [NDIG];
    logic [3:0]        hist_d [NDIG];
    logic              entering;

    assign entering = (STATE == ST_INPUT) && (prev_q != ST_INPUT);
    assign prev_d   = STATE;
    assign nHEX     = nhex_q;

`ifdef SEG7_GAME_BLINK_EN
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               blink_on;

    assign blink_d  = blink_q + 1'b1;
    assign blink_on = blink_q[BLINK_W-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    // A fresh entry wipes the history before the same-cycle strobe lands.
    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            hist_d[k] = entering ? 4'hF : hist_q[k];
        end
        if (STATE == ST_INPUT && DIN_VLD) begin
            for (int k = NDIG - 1; k > 0; k--) begin
                hist_d[k] = hist_d[k-1];
            end
            hist_d[0] = DIN;
        end
    end

    always_comb begin
        nhex_d = '1;
        unique case (1'b1)
            STATE == ST_READY: nhex_d[6:0] = G_A;
            STATE == ST_QUEST: nhex_d[6:0] = dig_glyph(QUE);
            STATE == ST_INPUT: begin
                if (!entering) begin
                    for (int k = 0; k < NDIG; k++) begin
                        nhex_d[7*k +: 7] = ans_glyph(hist_q[k]);
                    end
                end
            end
            STATE == ST_GOOD:  nhex_d[6:0] = G_O;
            STATE == ST_WRONG: nhex_d[6:0] = G_A;
            STATE == ST_OUCH:  nhex_d[6:0] = G_U;
            STATE == ST_DRAW:  nhex_d[6:0] = G_T;
            STATE == ST_WIN:   nhex_d[6:0] = G_E;
            STATE == ST_LOSE:  nhex_d[6:0] = G_O;
            default: ;
        endcase
`ifdef SEG7_GAME_BLINK_EN
        if ((STATE == ST_WRONG || STATE == ST_OUCH) && blink_on) begin
            nhex_d = '1;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nhex_q <= '1;
            prev_q <= 4'b0000;
            for (int k = 0; k < NDIG; k++) begin
                hist_q[k] <= 4'hF;
            end
        end else begin
            nhex_q <= nhex_d;
            prev_q <= prev_d;
            for (int k = 0; k < NDIG; k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

endmodule

// File: tb/tb_seg7_game_disp.sv
// Self-checking bench for seg7_game_disp against a queue-based behavioural model.
// Blink expectations follow SEG7_GAME_BLINK_EN when defined for the build.
module tb_seg7_game_disp;

    localparam int NDIG = 4;
    localparam int BW   = 4;
    localparam int W    = 7 * NDIG;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_A     = 7'b0001000;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_T     = 7'b0000111;
    localparam logic [6:0] G_E     = 7'b0000110;

    logic         CLK = 1'b0;
    logic         RST;
    logic [3:0]   STATE;
    logic [3:0]   QUE;
    logic [3:0]   DIN;
    logic         DIN_VLD;
    logic [W-1:0] nHEX;

    int errors = 0;
    int checks = 0;

    logic [6:0] dig_g [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1011000, 7'b0000000,
                               7'b0010000};
    int key_digit [10] = '{-1, 2, 3, 5, 7, 1, 3, 7, 9, 3};

    int         m_hist [$];
    logic [3:0] m_prev;
    int         m_cnt;
    logic [W-1:0] exp_hex;

    always #5 CLK = ~CLK;

    seg7_game_disp #(.NDIG(NDIG), .BLINK_W(BW)) dut (
        .CLK(CLK), .RST(RST), .STATE(STATE), .QUE(QUE),
        .DIN(DIN), .DIN_VLD(DIN_VLD), .nHEX(nHEX)
    );

    function automatic logic [6:0] key_glyph(int c);
        if (c == 0) return G_DASH;
        if (c >= 1 && c <= 9) return dig_g[key_digit[c]];
        return G_BLANK;
    endfunction

    function automatic logic [W-1:0] model_disp(int st, int q);
        logic [W-1:0] r;
        r = '1;
        case (st)
            2:  r[6:0] = G_A;
            3:  if (q <= 9) r[6:0] = dig_g[q];
            4:  if (m_prev == 4'd4)
                    for (int k = 0; k < NDIG; k++) r[7*k +: 7] = key_glyph(m_hist[k]);
            6:  r[6:0] = G_T;
            7:  r[6:0] = G_A;
            8:  r[6:0] = G_O;
            9:  r[6:0] = G_U;
            10: r[6:0] = G_E;
            11: r[6:0] = G_O;
            default: ;
        endcase
`ifdef SEG7_GAME_BLINK_EN
        if ((st == 7 || st == 9) && m_cnt >= (1 << (BW - 1))) r = '1;
`endif
        return r;
    endfunction

    task automatic step(input int st, input int q = 0, input int d = 0, input bit v = 0);
        STATE   = 4'(st);
        QUE     = 4'(q);
        DIN     = 4'(d);
        DIN_VLD = v;
        exp_hex = model_disp(st, q);
        if (st == 4) begin
            if (m_prev != 4'd4) m_hist = '{15, 15, 15, 15};
            if (v) begin
                m_hist.push_front(d);
                void'(m_hist.pop_back());
            end
        end
        m_prev = 4'(st);
        m_cnt  = (m_cnt + 1) % (1 << BW);
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_reset();
        RST = 1'b1;
        m_hist  = '{15, 15, 15, 15};
        m_prev  = 4'd0;
        m_cnt   = 0;
        exp_hex = '1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        STATE = 4'b0010; QUE = 4'd0; DIN = 4'd0; DIN_VLD = 1'b0;
        hold_reset();
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL reset_blank got=%h exp=%h", nHEX, {W{1'b1}});
        end
        release_reset();
        step(2);
        checks++;
        if (nHEX !== {{(W-7){1'b1}}, 7'b0001000}) begin
            errors++; $display("FAIL ready_glyph got=%h exp=%h", nHEX, {{(W-7){1'b1}}, 7'b0001000});
        end
    endtask

    task automatic test_question();
        step(3, 7);
        checks++;
        if (nHEX !== {{(W-7){1'b1}}, 7'b1011000}) begin
            errors++; $display("FAIL que7 got=%h exp=%h", nHEX, {{(W-7){1'b1}}, 7'b1011000});
        end
        step(3, 12);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL que12 got=%h exp=%h", nHEX, {W{1'b1}});
        end
        for (int i = 0; i < 8; i++) begin
            step(3, $urandom_range(15));
            checks++;
            if (nHEX !== exp_hex) begin
                errors++; $display("FAIL que_rand got=%h exp=%h", nHEX, exp_hex);
            end
        end
    endtask

    task automatic test_input();
        int seq [5] = '{1, 2, 3, 4, 8};
        for (int i = 0; i < 5; i++) begin
            step(4, 0, seq[i], 1'b1);
            checks++;
            if (nHEX !== exp_hex) begin
                errors++; $display("FAIL input_seq%0d got=%h exp=%h", i, nHEX, exp_hex);
            end
        end
        step(4);
        checks++;
        if (nHEX !== {7'b0110000, 7'b0010010, 7'b1011000, 7'b0010000}) begin
            errors++;
            $display("FAIL input_final got=%h exp=%h", nHEX,
                     {7'b0110000, 7'b0010010, 7'b1011000, 7'b0010000});
        end
    endtask

    task automatic test_leave_return();
        step(8);
        checks++;
        if (nHEX !== {{(W-7){1'b1}}, G_O}) begin
            errors++; $display("FAIL good_glyph got=%h exp=%h", nHEX, {{(W-7){1'b1}}, G_O});
        end
        step(3, 1, 5, 1'b1);
        step(4);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL return_blank got=%h exp=%h", nHEX, {W{1'b1}});
        end
        step(4);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL cleared_hist got=%h exp=%h", nHEX, {W{1'b1}});
        end
        step(4, 0, 0, 1'b1);
        step(3, 0, 7, 1'b1);
        step(3, 0, 9, 1'b1);
        step(4, 0, 2, 1'b1);
        step(4);
        checks++;
        if (nHEX !== exp_hex) begin
            errors++; $display("FAIL ignore_vld got=%h exp=%h", nHEX, exp_hex);
        end
    endtask

    task automatic test_other_states();
        step(5);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL state5 got=%h exp=%h", nHEX, {W{1'b1}});
        end
        step(15);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL state15 got=%h exp=%h", nHEX, {W{1'b1}});
        end
        for (int s = 0; s < 16; s++) begin
            step(s, $urandom_range(15));
            checks++;
            if (nHEX !== exp_hex) begin
                errors++; $display("FAIL state_sweep%0d got=%h exp=%h", s, nHEX, exp_hex);
            end
        end
    endtask

    task automatic test_blink();
        for (int i = 0; i < 20; i++) begin
            step((i < 10) ? 7 : 9);
            checks++;
            if (nHEX !== exp_hex) begin
                errors++; $display("FAIL blink%0d got=%h exp=%h", i, nHEX, exp_hex);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(4, 0, 3, 1'b1);
        step(4, 0, 4, 1'b1);
        hold_reset();
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL midreset_blank got=%h exp=%h", nHEX, {W{1'b1}});
        end
        STATE = 4'd4;
        release_reset();
        step(4, 0, 6, 1'b1);
        checks++;
        if (nHEX !== {W{1'b1}}) begin
            errors++; $display("FAIL midreset_fresh got=%h exp=%h", nHEX, {W{1'b1}});
        end
        step(4);
        checks++;
        if (nHEX !== {{(W-7){1'b1}}, 7'b0110000}) begin
            errors++; $display("FAIL midreset_first got=%h exp=%h", nHEX, {{(W-7){1'b1}}, 7'b0110000});
        end
    endtask

    task automatic test_random();
        int pick [14] = '{2, 3, 4, 4, 4, 4, 6, 7, 8, 9, 10, 11, 0, 5};
        int st;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(9) == 0) ? pick[$urandom_range(13)] :
                 (($urandom_range(3) == 0) ? 3 : 4);
            step(st, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
            checks++;
            if (nHEX !== exp_hex) begin
                errors++; $display("FAIL random%0d st=%0d got=%h exp=%h", i, st, nHEX, exp_hex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_question();
        test_input();
        test_leave_return();
        test_other_states();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
